// File: rtl/vread_stream.sv
// vread_stream: Versat read unit.
// The fetch engine copies `size` words from external memory over the databus
// into an internal buffer. The stream engine then replays buffer words on out0
// using a period/duty/iteration address pattern.
// Optional build macro VREAD_PINGPONG_EN: the buffer has two banks. Fetch fills
// one bank while stream replays the other, so a run streams the data fetched by
// the previous run. Without the macro the buffer has one bank, and stream
// starts only after fetch completes, so each run streams its own data.
module vread_stream #(
  parameter int DATA_W     = 32,
  parameter int IO_ADDR_W  = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int IO_SIZE_W  = 11,
  parameter int PERIOD_W   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  done,
  output logic                  databus_valid,
  input  logic                  databus_ready,
  output logic [IO_ADDR_W-1:0]  databus_addr,
  input  logic [DATA_W-1:0]     databus_rdata,
  output logic [DATA_W-1:0]     databus_wdata,
  output logic [DATA_W/8-1:0]   databus_wstrb,
  output logic [DATA_W-1:0]     out0,
  input  logic [IO_ADDR_W-1:0]  ext_addr,
  input  logic [MEM_ADDR_W-1:0] int_addr,
  input  logic [IO_SIZE_W-1:0]  size,
  input  logic [MEM_ADDR_W-1:0] iter,
  input  logic [PERIOD_W-1:0]   per,
  input  logic [PERIOD_W-1:0]   duty,
  input  logic [MEM_ADDR_W-1:0] start,
  input  logic [MEM_ADDR_W-1:0] shift,
  input  logic [MEM_ADDR_W-1:0] incr,
  input  logic [PERIOD_W-1:0]   delay
);

`ifdef VREAD_PINGPONG_EN
  localparam int RAM_AW = MEM_ADDR_W + 1;
`else
  localparam int RAM_AW = MEM_ADDR_W;
`endif
  localparam logic [IO_ADDR_W-1:0] ADDR_STEP = IO_ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_DONE = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GEN  = 2'd2,
    S_DONE = 2'd3
  } stream_state_t;

  fetch_state_t  f_state_r;
  stream_state_t s_state_r;

  // Configuration captured at an accepted run
  logic [MEM_ADDR_W-1:0] int_addr_r;
  logic [IO_SIZE_W-1:0]  size_r;
  logic [MEM_ADDR_W-1:0] iter_r;
  logic [PERIOD_W-1:0]   per_r;
  logic [PERIOD_W-1:0]   duty_r;
  logic [MEM_ADDR_W-1:0] start_r;
  logic [MEM_ADDR_W-1:0] shift_r;
  logic [MEM_ADDR_W-1:0] incr_r;
  logic [PERIOD_W-1:0]   delay_r;

  // Engine working state
  logic [IO_SIZE_W-1:0]  k_r;
  logic [MEM_ADDR_W-1:0] s_addr_r;
  logic [PERIOD_W-1:0]   j_r;
  logic [MEM_ADDR_W-1:0] i_r;
  logic [PERIOD_W-1:0]   wcnt_r;
`ifdef VREAD_PINGPONG_EN
  logic                  sel_r;
`endif

  logic [DATA_W-1:0] mem [0:(1<<RAM_AW)-1];

  logic                  wr_en_s;
  logic                  rd_en_s;
  logic [RAM_AW-1:0]     wr_addr_s;
  logic [RAM_AW-1:0]     rd_addr_s;
  logic [MEM_ADDR_W-1:0] wr_off_s;
  logic [MEM_ADDR_W-1:0] s_step_s;
  logic                  last_s;
  logic                  stream_go_s;

  assign databus_wdata = {DATA_W{1'b0}};
  assign databus_wstrb = {(DATA_W/8){1'b0}};

  assign wr_off_s = int_addr_r + MEM_ADDR_W'(k_r);
  assign wr_en_s  = (f_state_r == F_REQ) && databus_ready;
  assign rd_en_s  = (s_state_r == S_GEN) && (j_r < duty_r);
  assign s_step_s = rd_en_s ? incr_r : {MEM_ADDR_W{1'b0}};

  // Final GEN cycle: last active read of the last period, or the period end
  // when the duty is zero and no reads happen at all.
  assign last_s = (i_r == iter_r - MEM_ADDR_W'(1)) &&
                  ((duty_r == {PERIOD_W{1'b0}}) ? (j_r == per_r - PERIOD_W'(1))
                                                : (j_r == duty_r - PERIOD_W'(1)));

`ifdef VREAD_PINGPONG_EN
  assign wr_addr_s   = {~sel_r, wr_off_s};
  assign rd_addr_s   = {sel_r, s_addr_r};
  assign stream_go_s = 1'b1;
`else
  assign wr_addr_s   = wr_off_s;
  assign rd_addr_s   = s_addr_r;
  assign stream_go_s = (f_state_r == F_DONE);
`endif

  // Buffer write port, fed by accepted databus beats
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_addr_s] <= databus_rdata;
    end
  end

  // Run control plus fetch and stream engines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done          <= 1'b1;
      databus_valid <= 1'b0;
      databus_addr  <= {IO_ADDR_W{1'b0}};
      out0          <= {DATA_W{1'b0}};
      f_state_r     <= F_IDLE;
      s_state_r     <= S_IDLE;
      int_addr_r    <= {MEM_ADDR_W{1'b0}};
      size_r        <= {IO_SIZE_W{1'b0}};
      iter_r        <= {MEM_ADDR_W{1'b0}};
      per_r         <= {PERIOD_W{1'b0}};
      duty_r        <= {PERIOD_W{1'b0}};
      start_r       <= {MEM_ADDR_W{1'b0}};
      shift_r       <= {MEM_ADDR_W{1'b0}};
      incr_r        <= {MEM_ADDR_W{1'b0}};
      delay_r       <= {PERIOD_W{1'b0}};
      k_r           <= {IO_SIZE_W{1'b0}};
      s_addr_r      <= {MEM_ADDR_W{1'b0}};
      j_r           <= {PERIOD_W{1'b0}};
      i_r           <= {MEM_ADDR_W{1'b0}};
      wcnt_r        <= {PERIOD_W{1'b0}};
`ifdef VREAD_PINGPONG_EN
      sel_r         <= 1'b0;
`endif
    end else begin
      if (rd_en_s) begin
        out0 <= mem[rd_addr_s];
      end

      if (run && done) begin
        // Accept run: capture config and launch fetch
        done       <= 1'b0;
        int_addr_r <= int_addr;
        size_r     <= size;
        iter_r     <= iter;
        per_r      <= per;
        duty_r     <= (duty > per) ? per : duty;
        start_r    <= start;
        shift_r    <= shift;
        incr_r     <= incr;
        delay_r    <= delay;
        k_r        <= {IO_SIZE_W{1'b0}};
        databus_addr <= ext_addr;
        if (size == {IO_SIZE_W{1'b0}}) begin
          databus_valid <= 1'b0;
          f_state_r     <= F_DONE;
        end else begin
          databus_valid <= 1'b1;
          f_state_r     <= F_REQ;
        end
      end else begin
        case (f_state_r)
          F_IDLE: f_state_r <= F_IDLE;
          F_REQ: begin
            if (databus_ready) begin
              k_r          <= k_r + IO_SIZE_W'(1);
              databus_addr <= databus_addr + ADDR_STEP;
              if (k_r + IO_SIZE_W'(1) == size_r) begin
                databus_valid <= 1'b0;
                f_state_r     <= F_DONE;
              end
            end
          end
          F_DONE: f_state_r <= F_DONE;
          default: begin
            databus_valid <= 1'b0;
            f_state_r     <= F_IDLE;
          end
        endcase

        case (s_state_r)
          S_IDLE: begin
            if (!done && stream_go_s) begin
              s_addr_r <= start_r;
              j_r      <= {PERIOD_W{1'b0}};
              i_r      <= {MEM_ADDR_W{1'b0}};
              wcnt_r   <= delay_r;
              if ((iter_r == {MEM_ADDR_W{1'b0}}) || (per_r == {PERIOD_W{1'b0}})) begin
                s_state_r <= S_DONE;
              end else if (delay_r != {PERIOD_W{1'b0}}) begin
                s_state_r <= S_WAIT;
              end else begin
                s_state_r <= S_GEN;
              end
            end
          end
          S_WAIT: begin
            wcnt_r <= wcnt_r - PERIOD_W'(1);
            if (wcnt_r == PERIOD_W'(1)) begin
              s_state_r <= S_GEN;
            end
          end
          S_GEN: begin
            if (j_r == per_r - PERIOD_W'(1)) begin
              j_r      <= {PERIOD_W{1'b0}};
              i_r      <= i_r + MEM_ADDR_W'(1);
              s_addr_r <= s_addr_r + s_step_s + shift_r;
            end else begin
              j_r      <= j_r + PERIOD_W'(1);
              s_addr_r <= s_addr_r + s_step_s;
            end
            if (last_s) begin
              s_state_r <= S_DONE;
            end
          end
          S_DONE: s_state_r <= S_DONE;
          default: s_state_r <= S_IDLE;
        endcase

        // Both engines finished: report done and return to idle
        if ((f_state_r == F_DONE) && (s_state_r == S_DONE)) begin
          done      <= 1'b1;
          f_state_r <= F_IDLE;
          s_state_r <= S_IDLE;
`ifdef VREAD_PINGPONG_EN
          sel_r     <= ~sel_r;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_vread_stream.sv
// Scoreboard bench for vread_stream: expected bus addresses and out0 words are
// queued by the stimulus, a monitor pops and compares them as the DUT produces
// them. Memory returns rdata = 0xD0000000 + byte address.
module tb_vread_stream;
  localparam int DATA_W = 32, IO_ADDR_W = 32, MEM_ADDR_W = 10, IO_SIZE_W = 11, PERIOD_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  logic done, databus_valid;
  logic databus_ready = 1'b1;
  logic [IO_ADDR_W-1:0] databus_addr;
  logic [DATA_W-1:0] databus_rdata = '0;
  logic [DATA_W-1:0] databus_wdata, out0;
  logic [DATA_W/8-1:0] databus_wstrb;
  logic [IO_ADDR_W-1:0] ext_addr = '0;
  logic [MEM_ADDR_W-1:0] int_addr = '0, iter = '0, start = '0, shift = '0, incr = '0;
  logic [IO_SIZE_W-1:0] size = '0;
  logic [PERIOD_W-1:0] per = '0, duty = '0, delay = '0;

  vread_stream dut (
    .clk(clk), .rst(rst), .run(run), .done(done),
    .databus_valid(databus_valid), .databus_ready(databus_ready),
    .databus_addr(databus_addr), .databus_rdata(databus_rdata),
    .databus_wdata(databus_wdata), .databus_wstrb(databus_wstrb),
    .out0(out0), .ext_addr(ext_addr), .int_addr(int_addr), .size(size),
    .iter(iter), .per(per), .duty(duty), .start(start), .shift(shift),
    .incr(incr), .delay(delay)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [IO_ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_out_q[$];
  logic [DATA_W-1:0] prev_out = '0;
  logic [IO_ADDR_W-1:0] stall_addr = '0;
  int stall_left = 0;
  int valid_cycles = 0;
  int last_out_cyc = 0;
  int done_cyc = 0;
  int lat = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: drives ready/rdata, stalling a chosen address
  initial begin
    forever begin
      @(negedge clk);
      if (databus_valid && stall_left > 0 && databus_addr == stall_addr) begin
        databus_ready = 1'b0;
        stall_left--;
      end else begin
        databus_ready = 1'b1;
      end
      databus_rdata = 32'hD000_0000 + databus_addr;
    end
  end

  // Monitor: compares accepted bus beats and every new out0 word
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (databus_valid) valid_cycles++;
        if (databus_valid && databus_ready) begin
          if (exp_addr_q.size() == 0) begin
            total++; bad++;
            $display("FAIL bus_extra: got addr %0h expected no request", databus_addr);
          end else begin
            check("bus_addr", databus_addr, exp_addr_q.pop_front());
          end
        end else if (databus_valid && exp_addr_q.size() != 0) begin
          check("stall_addr", databus_addr, exp_addr_q[0]);
        end
        if (out0 !== prev_out) begin
          if (exp_out_q.size() == 0) begin
            total++; bad++;
            $display("FAIL out0_extra: got %0h expected no new word", out0);
          end else begin
            check("out0", out0, exp_out_q.pop_front());
          end
          prev_out = out0;
          last_out_cyc = cyc;
        end
      end
    end
  end

  task automatic do_run(input logic [31:0] e, input logic [9:0] ia, input logic [10:0] sz,
                        input logic [9:0] it, input logic [9:0] pr, input logic [9:0] dt,
                        input logic [9:0] st, input logic [9:0] sh, input logic [9:0] inc,
                        input logic [9:0] dl);
    @(negedge clk);
    ext_addr = e; int_addr = ia; size = sz; iter = it; per = pr; duty = dt;
    start = st; shift = sh; incr = inc; delay = dl;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      #1;
      n++;
      if (done) break;
    end
    check("done_rise", done, 1);
    done_cyc = cyc;
  endtask

  task automatic queues_empty(input string tag);
    check({tag, "_bus_q"}, exp_addr_q.size(), 0);
    check({tag, "_out_q"}, exp_out_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_done", done, 1);
    check("rst_valid", databus_valid, 0);
    check("rst_addr", databus_addr, 0);
    check("rst_out0", out0, 0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    // size=0, iter=0: no bus traffic, done back two cycles after dropping
    valid_cycles = 0;
    do_run(32'h0, 10'd0, 11'd0, 10'd0, 10'd4, 10'd4, 10'd0, 10'd0, 10'd1, 10'd0);
    #1;
    check("zero_done_drop", done, 0);
    wait_done(20, lat);
    check("zero_latency", lat, 2);
    check("zero_valid_cycles", valid_cycles, 0);
    queues_empty("zero");

`ifdef VREAD_PINGPONG_EN
    // Ping-pong: each run streams what the previous run fetched
    exp_addr_q = '{32'h700, 32'h704};
    do_run(32'h700, 10'd0, 11'd2, 10'd0, 10'd2, 10'd2, 10'd0, 10'd0, 10'd1, 10'd0);
    wait_done(50, lat);
    queues_empty("pp1");
    exp_addr_q = '{32'h800, 32'h804};
    exp_out_q  = '{32'hD000_0700, 32'hD000_0704};
    do_run(32'h800, 10'd0, 11'd2, 10'd1, 10'd2, 10'd2, 10'd0, 10'd0, 10'd1, 10'd0);
    wait_done(50, lat);
    queues_empty("pp2");
    exp_out_q  = '{32'hD000_0800, 32'hD000_0804};
    do_run(32'h0, 10'd0, 11'd0, 10'd1, 10'd2, 10'd2, 10'd0, 10'd0, 10'd1, 10'd0);
    wait_done(50, lat);
    queues_empty("pp3");
`else
    // Single fetch, back-to-back beats, then stream words 0..3
    valid_cycles = 0;
    exp_addr_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    exp_out_q  = '{32'hD000_0100, 32'hD000_0104, 32'hD000_0108, 32'hD000_010C};
    do_run(32'h100, 10'd0, 11'd4, 10'd1, 10'd4, 10'd4, 10'd0, 10'd0, 10'd1, 10'd0);
    #1;
    check("t1_done_drop", done, 0);
    wait_done(100, lat);
    check("t1_valid_cycles", valid_cycles, 4);
    check("t1_done_after_last", done_cyc - last_out_cyc, 1);
    queues_empty("t1");

    // Backpressure: word 2 stalled for three cycles
    valid_cycles = 0;
    stall_addr = 32'h208;
    stall_left = 3;
    exp_addr_q = '{32'h200, 32'h204, 32'h208, 32'h20C};
    exp_out_q  = '{32'hD000_0200, 32'hD000_0204, 32'hD000_0208, 32'hD000_020C};
    do_run(32'h200, 10'h10, 11'd4, 10'd1, 10'd4, 10'd4, 10'h10, 10'd0, 10'd1, 10'd0);
    wait_done(100, lat);
    check("t2_valid_cycles", valid_cycles, 7);
    queues_empty("t2");

    // Pattern: iter=2 per=4 duty=2 incr=1 shift=2 delay=2 -> mem 0,1,4,5
    exp_addr_q = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h310, 32'h314, 32'h318, 32'h31C};
    exp_out_q  = '{32'hD000_0300, 32'hD000_0304, 32'hD000_0310, 32'hD000_0314};
    do_run(32'h300, 10'd0, 11'd8, 10'd2, 10'd4, 10'd2, 10'd0, 10'd2, 10'd1, 10'd2);
    wait_done(100, lat);
    check("t3_done_after_last", done_cyc - last_out_cyc, 1);
    queues_empty("t3");

    // Wrap: fetch into 0x3FF,0x000 and stream from 0x3FF with incr=1
    exp_addr_q = '{32'h400, 32'h404};
    exp_out_q  = '{32'hD000_0400, 32'hD000_0404};
    do_run(32'h400, 10'h3FF, 11'd2, 10'd1, 10'd2, 10'd2, 10'h3FF, 10'd0, 10'd1, 10'd0);
    wait_done(100, lat);
    queues_empty("t5");

    // Run pulsed while busy is ignored
    valid_cycles = 0;
    exp_addr_q = '{32'h500, 32'h504, 32'h508, 32'h50C};
    exp_out_q  = '{32'hD000_0500, 32'hD000_0504, 32'hD000_0508, 32'hD000_050C};
    do_run(32'h500, 10'd0, 11'd4, 10'd1, 10'd4, 10'd4, 10'd0, 10'd0, 10'd1, 10'd0);
    do_run(32'h900, 10'd7, 11'd1, 10'd1, 10'd1, 10'd1, 10'd7, 10'd0, 10'd1, 10'd0);
    wait_done(100, lat);
    repeat (5) @(negedge clk);
    #1;
    check("t6_done_held", done, 1);
    check("t6_valid_cycles", valid_cycles, 4);
    queues_empty("t6");
`endif

    // Async reset in the middle of a stalled fetch
    stall_addr = 32'h608;
    stall_left = 20;
    exp_addr_q = '{32'h600, 32'h604, 32'h608};
    do_run(32'h600, 10'h20, 11'd8, 10'd1, 10'd8, 10'd8, 10'h20, 10'd0, 10'd1, 10'd0);
    repeat (4) @(negedge clk);
    #1;
    check("t7_valid_before", databus_valid, 1);
    mon_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("t7_valid_reset", databus_valid, 0);
    check("t7_done_reset", done, 1);
    check("t7_out0_reset", out0, 0);
    exp_addr_q.delete();
    exp_out_q.delete();
    stall_left = 0;
    prev_out = '0;
    @(negedge clk);
    rst = 1'b1;
    valid_cycles = 0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("t7_done_after", done, 1);
    check("t7_valid_after", databus_valid, 0);
    check("t7_valid_cycles", valid_cycles, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
